// File: rtl/smps_pkg.sv
// ---------------------------------------------------------------------------
// smps_pkg
// Shared widths, FSM encoding and arithmetic helpers for the SMPS digital
// control path (PID compensator, clamp, future feed-forward blocks).
//   ADC_W  : ADC sample / reference width (unsigned)
//   COEF_W : PID coefficient width (signed Q4.8)
//   FRAC   : fractional bits of coefficients and accumulator
//   ACC_W  : accumulator width (signed, FRAC fractional bits)
//   TON_W  : DPWM on-time width
// ---------------------------------------------------------------------------
package smps_pkg;

   localparam int ADC_W  = 10;
   localparam int COEF_W = 12;
   localparam int FRAC   = 8;
   localparam int ACC_W  = 24;
   localparam int TON_W  = 11;

   // Error term is ref - adc, one extra bit for the sign.
   localparam int E_W    = ADC_W + 1;
   localparam int PROD_W = COEF_W + E_W;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MAC0 = 3'd1,
      MAC1 = 3'd2,
      MAC2 = 3'd3,
      SAT  = 3'd4
   } pid_state_t;

   // ACC_W-bit signed add that pins to the most positive / most negative
   // value instead of wrapping. Overflow is only possible when both operands
   // share a sign and the sum's sign differs from it.
   function automatic logic signed [ACC_W-1:0] sat_add(
      input logic signed [ACC_W-1:0] a,
      input logic signed [ACC_W-1:0] b
   );
      logic signed [ACC_W-1:0] sum;
      sum = a + b;
      if ((a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]))
         sat_add = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
      else
         sat_add = sum;
   endfunction

endpackage

// File: rtl/pid_clamp.sv
// ---------------------------------------------------------------------------
// pid_clamp
// Combinational clamp of a Q.FRAC accumulator value to the legal on-time
// window [TON_MIN, TON_MAX] << FRAC, plus truncation to an integer on-time.
// Ports:
//   acc        in   ACC_W  signed accumulator value
//   u_clamped  out  ACC_W  acc limited to the on-time window (still Q.FRAC)
//   ton        out  TON_W  u_clamped >> FRAC, fractional bits truncated
// ---------------------------------------------------------------------------
module pid_clamp
   import smps_pkg::*;
#(
   parameter int TON_MIN = 20,
   parameter int TON_MAX = 1800
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] u_clamped,
   output logic        [TON_W-1:0] ton
);

   localparam logic signed [ACC_W-1:0] U_MIN = ACC_W'(TON_MIN * (2 ** FRAC));
   localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'(TON_MAX * (2 ** FRAC));

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch cannot be inferred.
   always_comb begin
      u_clamped = acc;
      if (acc < U_MIN)
         u_clamped = U_MIN;
      else if (acc > U_MAX)
         u_clamped = U_MAX;
   end

   // The clamped value is never negative, so a plain bit slice is the
   // truncating shift.
   assign ton = u_clamped[FRAC +: TON_W];

endmodule

// File: rtl/pid_ton_comp.sv
// ---------------------------------------------------------------------------
// pid_ton_comp
// Incremental PID compensator feeding the DPWM on-time input:
//   u[n] = u[n-1] + A*e[n] + B*e[n-1] + C*e[n-2],  e = ref_eff - adc
// One shared signed multiplier, sequenced IDLE->MAC0->MAC1->MAC2->SAT.
// The clamp in SAT doubles as anti-windup: u never leaves the on-time range.
// Build option: define SOFTSTART_EN to ramp the effective reference from 0
// toward i_ref by one LSB per accepted sample.
// Ports:
//   i_clk        in   1       system clock, shared with DPWM
//   reset        in   1       synchronous active-high reset
//   enable       in   1       compensator enable (low = hold in reset state)
//   i_adc        in   ADC_W   output-voltage sample, unsigned
//   i_adc_valid  in   1       sample strobe, one cycle
//   i_ref        in   ADC_W   voltage reference, unsigned
//   i_ka/kb/kc   in   COEF_W  PID coefficients, signed Q4.8
//   o_ton        out  TON_W   on-time to DPWM
//   o_ton_valid  out  1       one-cycle strobe: o_ton updated
//   o_busy       out  1       high while a sample is being processed
// ---------------------------------------------------------------------------
module pid_ton_comp
   import smps_pkg::*;
#(
   parameter int TON_MIN = 20,
   parameter int TON_MAX = 1800
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADC_W-1:0]  i_adc,
   input  logic              i_adc_valid,
   input  logic [ADC_W-1:0]  i_ref,
   input  logic [COEF_W-1:0] i_ka,
   input  logic [COEF_W-1:0] i_kb,
   input  logic [COEF_W-1:0] i_kc,
   output logic [TON_W-1:0]  o_ton,
   output logic              o_ton_valid,
   output logic              o_busy
);

   localparam logic signed [ACC_W-1:0] U_RESET = ACC_W'(TON_MIN * (2 ** FRAC));

   pid_state_t               state;
   logic signed [ACC_W-1:0]  u;
   logic signed [ACC_W-1:0]  acc;
   logic signed [E_W-1:0]    e0, e1, e2;
   logic [ADC_W-1:0]         ref_eff;
   logic signed [E_W-1:0]    e_new;

   logic signed [COEF_W-1:0] coef_sel;
   logic signed [E_W-1:0]    e_sel;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  u_clamped;
   logic        [TON_W-1:0]  ton_clamped;

`ifndef SOFTSTART_EN
   assign ref_eff = i_ref;
`endif

   // Both operands zero-extended by one bit, so the difference is the
   // correctly signed error in E_W bits.
   assign e_new = $signed({1'b0, ref_eff} - {1'b0, i_adc});

   // Operand select for the shared multiplier.
   always_comb begin
      coef_sel = $signed(i_ka);
      e_sel    = e0;
      case (state)
         MAC1: begin
            coef_sel = $signed(i_kb);
            e_sel    = e1;
         end
         MAC2: begin
            coef_sel = $signed(i_kc);
            e_sel    = e2;
         end
         default: ;
      endcase
   end

   assign prod     = {{(PROD_W-COEF_W){coef_sel[COEF_W-1]}}, coef_sel}
                   * {{(PROD_W-E_W){e_sel[E_W-1]}}, e_sel};
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   pid_clamp #(
      .TON_MIN (TON_MIN),
      .TON_MAX (TON_MAX)
   ) u_clamp (
      .acc       (acc),
      .u_clamped (u_clamped),
      .ton       (ton_clamped)
   );

   // NOTE: state registers use non-blocking assignments so every register
   // in this block sees the pre-edge value of every other (e.g. e2 <= e1 and
   // e1 <= e0 in the same edge form a proper shift).
   always_ff @(posedge i_clk) begin
      // Dropping enable is a soft reset: any in-flight sample is discarded.
      if (reset || !enable) begin
         state       <= IDLE;
         u           <= U_RESET;
         acc         <= '0;
         e0          <= '0;
         e1          <= '0;
         e2          <= '0;
         o_ton       <= TON_W'(TON_MIN);
         o_ton_valid <= 1'b0;
         o_busy      <= 1'b0;
`ifdef SOFTSTART_EN
         ref_eff     <= '0;
`endif
      end else begin
         o_ton_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_adc_valid) begin
                  e0     <= e_new;
                  state  <= MAC0;
                  o_busy <= 1'b1;
`ifdef SOFTSTART_EN
                  // e_new above used the pre-step value of ref_eff.
                  if (ref_eff < i_ref)
                     ref_eff <= ref_eff + 1'b1;
                  else if (ref_eff > i_ref)
                     ref_eff <= ref_eff - 1'b1;
`endif
               end
            end
            MAC0: begin
               acc   <= sat_add(u, prod_ext);
               state <= MAC1;
            end
            MAC1: begin
               acc   <= sat_add(acc, prod_ext);
               state <= MAC2;
            end
            MAC2: begin
               acc   <= sat_add(acc, prod_ext);
               state <= SAT;
            end
            SAT: begin
               u           <= u_clamped;
               o_ton       <= ton_clamped;
               o_ton_valid <= 1'b1;
               e2          <= e1;
               e1          <= e0;
               o_busy      <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
